// File: rtl/hazard_ctrl_unit.sv
// Load-use / taken-branch hazard controller for the ID stage: multi-cycle stalls and flushes.
// Optional macro HAZARD_PERF_CNT_EN adds saturating StallCount/FlushCount cycle counters.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRt,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt,
  input  logic                  IF_ID_UsesRs,
  input  logic                  IF_ID_UsesRt,
  input  logic                  in_BranchControl,
  output logic                  Stall,
  output logic                  Flush,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Bubble
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           StallCount,
  output logic [31:0]           FlushCount
`endif
);

  localparam int MAX_CYCLES = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STALL,
    S_FLUSH
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;
  logic             stall_d, flush_d;

  // Register 0 is hard-wired, so a load targeting it can never create a dependency.
  assign hz = ID_EX_MemRead && (ID_EX_RegisterRt != '0) &&
              ((IF_ID_UsesRs && (ID_EX_RegisterRt == IF_ID_RegisterRs)) ||
               (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    flush_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_BranchControl) begin
          flush_d = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (hz) begin
          stall_d = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = S_STALL;
            cnt_d   = STALL_RELOAD;
          end
        end
      end
      S_STALL: begin
        stall_d = 1'b1;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_IDLE;
      end
      S_FLUSH: begin
        flush_d = 1'b1;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Reset overrides the outputs in the same cycle, independent of any pending sequence.
    if (!reset) begin
      stall_d = 1'b0;
      flush_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Stall        = stall_d;
  assign Flush        = flush_d;
  assign PCWrite      = !stall_d;
  assign IF_ID_Write  = !stall_d;
  assign ID_EX_Bubble = stall_d | flush_d;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_d && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_d && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit (LOAD_STALL_CYCLES=3, FLUSH_CYCLES=2).
// Expected outputs come from a remaining-cycles model and flow through a scoreboard queue.
module tb_hazard_ctrl_unit;

  localparam int AW = 5;
  localparam int L  = 3;
  localparam int F  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          ID_EX_MemRead;
  logic [AW-1:0] ID_EX_RegisterRt;
  logic [AW-1:0] IF_ID_RegisterRs;
  logic [AW-1:0] IF_ID_RegisterRt;
  logic          IF_ID_UsesRs;
  logic          IF_ID_UsesRt;
  logic          in_BranchControl;
  logic          Stall, Flush, PCWrite, IF_ID_Write, ID_EX_Bubble;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   StallCount, FlushCount;
`endif

  hazard_ctrl_unit #(
    .REG_ADDR_W       (AW),
    .LOAD_STALL_CYCLES(L),
    .FLUSH_CYCLES     (F)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ID_EX_MemRead   (ID_EX_MemRead),
    .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .IF_ID_RegisterRs(IF_ID_RegisterRs),
    .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .IF_ID_UsesRs    (IF_ID_UsesRs),
    .IF_ID_UsesRt    (IF_ID_UsesRt),
    .in_BranchControl(in_BranchControl),
    .Stall           (Stall),
    .Flush           (Flush),
    .PCWrite         (PCWrite),
    .IF_ID_Write     (IF_ID_Write),
    .ID_EX_Bubble    (ID_EX_Bubble)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCount      (StallCount),
    .FlushCount      (FlushCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic stall;
    logic flush;
    logic pcw;
    logic ifidw;
    logic bubble;
  } exp_t;

  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  int    rem_stall = 0;
  int    rem_flush = 0;
  int    stall_seen = 0;
  int    flush_seen = 0;
  int    m_scnt = 0;
  int    m_fcnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h at %0t", phase, tag, obs, expv, $time);
    end
  endtask

  // One clock cycle: drive at negedge, predict, sample mid-low-phase, compare.
  task automatic step(input logic rst, input logic mr, input logic [AW-1:0] ex_rt,
                      input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic urs, input logic urt, input logic br);
    exp_t e;
    exp_t got;
    logic hz;
    @(negedge clk);
    reset            = rst;
    ID_EX_MemRead    = mr;
    ID_EX_RegisterRt = ex_rt;
    IF_ID_RegisterRs = rs;
    IF_ID_RegisterRt = rt;
    IF_ID_UsesRs     = urs;
    IF_ID_UsesRt     = urt;
    in_BranchControl = br;

    hz = mr && (ex_rt != 0) && ((urs && ex_rt == rs) || (urt && ex_rt == rt));
    e  = '0;
    if (!rst) begin
      rem_stall = 0;
      rem_flush = 0;
    end else if (rem_flush > 0) begin
      e.flush = 1'b1;
      rem_flush--;
    end else if (rem_stall > 0) begin
      e.stall = 1'b1;
      rem_stall--;
    end else if (br) begin
      e.flush   = 1'b1;
      rem_flush = F - 1;
    end else if (hz) begin
      e.stall   = 1'b1;
      rem_stall = L - 1;
    end
    e.pcw    = !e.stall;
    e.ifidw  = !e.stall;
    e.bubble = e.stall | e.flush;
    sb_q.push_back(e);

    #2;
    got = sb_q.pop_front();
    check("Stall",        {31'd0, Stall},        {31'd0, got.stall});
    check("Flush",        {31'd0, Flush},        {31'd0, got.flush});
    check("PCWrite",      {31'd0, PCWrite},      {31'd0, got.pcw});
    check("IF_ID_Write",  {31'd0, IF_ID_Write},  {31'd0, got.ifidw});
    check("ID_EX_Bubble", {31'd0, ID_EX_Bubble}, {31'd0, got.bubble});
`ifdef HAZARD_PERF_CNT_EN
    check("StallCount", StallCount, m_scnt);
    check("FlushCount", FlushCount, m_fcnt);
`endif
    if (Stall) stall_seen++;
    if (Flush) flush_seen++;
    if (!rst) begin
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
      m_scnt += int'(got.stall);
      m_fcnt += int'(got.flush);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    ID_EX_MemRead = 1'b0;
    ID_EX_RegisterRt = '0;
    IF_ID_RegisterRs = '0;
    IF_ID_RegisterRt = '0;
    IF_ID_UsesRs = 1'b0;
    IF_ID_UsesRt = 1'b0;
    in_BranchControl = 1'b0;

    phase = "reset_hold";
    step(1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1);
    check("pcw_forced", {31'd0, PCWrite}, 32'd1);

    phase = "reset_release";
    flush_seen = 0;
    step(1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1);
    check("flush_same_cycle", {31'd0, Flush}, 32'd1);
    idle(3);
    check("flush_run", flush_seen, F);

    phase = "clean_reset";
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle(1);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_cleared_s", StallCount, 32'd0);
    check("perf_cleared_f", FlushCount, 32'd0);
`endif

    phase = "load_use";
    stall_seen = 0;
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(5);
    check("stall_run", stall_seen, L);

    phase = "branch_beats_hz";
    stall_seen = 0;
    flush_seen = 0;
    step(1'b1, 1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1);
    idle(4);
    check("flush_run", flush_seen, F);
    check("no_stall", stall_seen, 0);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_total_s", StallCount, 32'd3);
    check("perf_total_f", FlushCount, 32'd2);
    phase = "perf_reset";
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("perf_zero_s", StallCount, 32'd0);
    check("perf_zero_f", FlushCount, 32'd0);
`endif

    phase = "filter";
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);
    phase = "uses_rt";
    step(1'b1, 1'b1, 5'd7, 5'd2, 5'd7, 1'b0, 1'b1, 1'b0);
    idle(3);

    phase = "mid_reset";
    stall_seen = 0;
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("stall_after_abort", stall_seen, 1);

    phase = "back_to_back";
    step(1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < L; i++) step(1'b1, 1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1);
    idle(6);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) != 0),
           1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised load-use and control hazard controller for the ID stage of the pipelined core. It generalises the single-cycle stall/flush detector. It adds a configurable register-address width, multi-cycle load-use stalls for slow memories, and multi-cycle branch flushes for deeper front ends. It also adds per-operand use qualifiers, register-0 filtering and explicit pipeline-register write enables. It sits between the IF/ID and ID/EX pipeline registers and drives PC and pipeline-register control.

## Interface
Parameters:
- REG_ADDR_W, 5, width of register specifiers
- LOAD_STALL_CYCLES, 1, total stall cycles per load-use hazard (≥1)
- FLUSH_CYCLES, 1, total flush cycles per taken branch (≥1)

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_RegisterRt  input  REG_ADDR_W  load destination register
- IF_ID_RegisterRs  input  REG_ADDR_W  ID-stage source A
- IF_ID_RegisterRt  input  REG_ADDR_W  ID-stage source B
- IF_ID_UsesRs  input  1  ID instruction reads Rs
- IF_ID_UsesRt  input  1  ID instruction reads Rt
- in_BranchControl  input  1  branch resolved taken this cycle
- Stall  output  1  hold PC and IF/ID
- Flush  output  1  squash IF/ID contents
- PCWrite  output  1  PC write enable (= !Stall)
- IF_ID_Write  output  1  IF/ID write enable (= !Stall)
- ID_EX_Bubble  output  1  insert NOP into ID/EX (= Stall | Flush)

## Operation
- Hazard term `hz` = ID_EX_MemRead && ID_EX_RegisterRt != 0 && ((IF_ID_UsesRs && Rt==Rs) || (IF_ID_UsesRt && Rt==IF_ID_RegisterRt)). Register 0 never causes a stall.
- FSM states are IDLE, STALL and FLUSH. Down-counter `cnt` is $clog2(max(LOAD_STALL_CYCLES,FLUSH_CYCLES)+1) bits wide.
- IDLE:
  - in_BranchControl=1: Flush=1 this cycle. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - else if hz: Stall=1 this cycle. If LOAD_STALL_CYCLES>1, go to STALL with cnt=LOAD_STALL_CYCLES-1.
  - else all idle: Stall=0, Flush=0.
- STALL: Stall=1. Detection inputs are ignored, since ID/EX holds a bubble. cnt decrements, and the FSM returns to IDLE when cnt reaches 1 on this cycle.
  - A branch is not resolved from a bubble, so in_BranchControl is ignored in STALL.
- FLUSH: Flush=1, Stall=0. cnt decrements and the FSM returns to IDLE after the last flush cycle. hz and in_BranchControl are ignored.
- Priority: a taken branch beats a load-use hazard in the same cycle. Flush=1 and Stall=0, because the stalled instruction is being squashed anyway.
- Stall and Flush are never both 1.
- Reset (reset=0 at an edge):
  - state=IDLE, cnt=0.
  - While reset is low, outputs are forced to Stall=0, Flush=0, PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, regardless of inputs.
  - Reset mid-STALL or mid-FLUSH abandons the sequence immediately.

## Timing
- Detection is combinational: the first Stall/Flush cycle is the same cycle the condition is presented (zero latency).
- A load-use hazard yields exactly LOAD_STALL_CYCLES consecutive Stall cycles. A taken branch yields exactly FLUSH_CYCLES consecutive Flush cycles.
- The first cycle after a sequence ends is IDLE and re-evaluates inputs, so back-to-back hazards are handled with no gap.
- Outputs are glitch-tolerant combinational functions of state, cnt and inputs. They are not registered.

## Configuration
- HAZARD_PERF_CNT_EN, when defined, adds two outputs: StallCount and FlushCount, each `output 32` bits.
  - Each counts cycles in which Stall (respectively Flush) is 1.
  - Counters saturate at 32'hFFFF_FFFF.
  - Both clear to 0 on reset.
- Without the macro, the ports and counters do not exist and the remaining behaviour is identical.

## Test plan
- Reset: reset=0 with ID_EX_MemRead=1, Rt=Rs=3, in_BranchControl=1 -> Stall=0, Flush=0, PCWrite=1, ID_EX_Bubble=0. Release reset -> Flush=1 in the same cycle.
- LOAD_STALL_CYCLES=3: MemRead=1, ID_EX_Rt=5, IF_ID_Rs=5, UsesRs=1, held for one cycle -> Stall=1, PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly 3 cycles, then 0.
- Filtering: Rt=0=Rs with MemRead=1 -> Stall=0. Rt=7=IF_ID_Rt with UsesRt=0 -> Stall=0.
- FLUSH_CYCLES=2: in_BranchControl pulse for one cycle together with a load-use hazard -> Flush=1 for 2 cycles, Stall=0 throughout.
- Reset mid-sequence: reset=0 on the 2nd cycle of a 3-cycle stall -> Stall=0 from that cycle. After release with inputs idle -> Stall stays 0.
- With HAZARD_PERF_CNT_EN, run the two sequences above (3-cycle stall, 2-cycle flush) -> StallCount=3, FlushCount=2. After reset -> both 0.
